// File: rtl/pipe_arbiter.sv
// Two-requester round-robin arbiter sharing one downstream enq pipe.
// Each requester owns a one-entry holding slot; messages are forwarded unmodified.
module pipe_arbiter #(
  parameter int WIDTH   = 96,
  parameter int COUNT_W = 16
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               in0_enq__ENA,
  input  logic [WIDTH-1:0]   in0_enq_v,
  output logic               in0_enq__RDY,
  input  logic               in1_enq__ENA,
  input  logic [WIDTH-1:0]   in1_enq_v,
  output logic               in1_enq__RDY,
  output logic               out_enq__ENA,
  output logic [WIDTH-1:0]   out_enq_v,
  input  logic               out_enq__RDY,
  output logic               out_src,
  output logic [COUNT_W-1:0] count0,
  output logic [COUNT_W-1:0] count1
);

  logic               r_valid0;
  logic               r_valid1;
  logic [WIDTH-1:0]   r_data0;
  logic [WIDTH-1:0]   r_data1;
  logic               r_last;
  logic [COUNT_W-1:0] r_count0;
  logic [COUNT_W-1:0] r_count1;

  logic w_grant;
  logic w_fire;
  logic w_take0;
  logic w_take1;

  // Grant depends only on registered state, so input RDY never reaches slot RDY.
  always_comb begin
    w_grant = r_last;
    if (r_valid0 && r_valid1) begin
      w_grant = ~r_last;
    end else if (r_valid1) begin
      w_grant = 1'b1;
    end else if (r_valid0) begin
      w_grant = 1'b0;
    end
  end

  assign w_fire  = (r_valid0 | r_valid1) & out_enq__RDY;
  assign w_take0 = in0_enq__ENA & ~r_valid0;
  assign w_take1 = in1_enq__ENA & ~r_valid1;

  assign in0_enq__RDY = ~r_valid0;
  assign in1_enq__RDY = ~r_valid1;
  assign out_enq__ENA = w_fire;
  assign out_enq_v    = w_grant ? r_data1 : r_data0;
  assign out_src      = w_grant;
  assign count0       = r_count0;
  assign count1       = r_count1;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid0 <= 1'b0;
      r_data0  <= '0;
    end else if (w_take0) begin
      r_valid0 <= 1'b1;
      r_data0  <= in0_enq_v;
    end else if (w_fire && !w_grant) begin
      r_valid0 <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid1 <= 1'b0;
      r_data1  <= '0;
    end else if (w_take1) begin
      r_valid1 <= 1'b1;
      r_data1  <= in1_enq_v;
    end else if (w_fire && w_grant) begin
      r_valid1 <= 1'b0;
    end
  end

  // Reset leaves last=1 so the first tie goes to requester 0.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_last   <= 1'b1;
      r_count0 <= '0;
      r_count1 <= '0;
    end else if (w_fire) begin
      r_last <= w_grant;
      if (w_grant) begin
        r_count1 <= r_count1 + 1'b1;
      end else begin
        r_count0 <= r_count0 + 1'b1;
      end
    end
  end

endmodule

// File: doc/pipe_arbiter.md
# pipe_arbiter

Two-requester arbiter that shares one downstream `enq` pipe between two portal output proxies (e.g. a request serializer and an indication serializer feeding a single transport link). Each requester gets a one-entry holding slot; a round-robin arbiter forwards held messages onto the shared pipe unchanged. The arbiter also reports which requester was granted and keeps per-requester forwarded-message counters. It sits between the proxy `pipe$enq` outputs and the transport input.

## Interface
- `WIDTH`, 96: message width in bits; messages pass through unmodified.
- `COUNT_W`, 16: width of the per-requester message counters.

- `CLK`  in  1  clock, all state on rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `in0$enq__ENA`  in  1  requester 0 enqueue; asserted only while `in0$enq__RDY`=1.
- `in0$enq$v`  in  WIDTH  requester 0 message.
- `in0$enq__RDY`  out  1  requester 0 slot empty.
- `in1$enq__ENA` / `in1$enq$v` / `in1$enq__RDY`: same for requester 1.
- `out$enq__ENA`  out  1  forward a message this cycle.
- `out$enq$v`  out  WIDTH  forwarded message.
- `out$enq__RDY`  in  1  downstream can accept.
- `out$src`  out  1  index of requester whose message is on `out$enq$v`.
- `count0`, `count1`  out  COUNT_W  messages forwarded from each requester.

## Operation
- State: `slot0`/`slot1` (valid bit + WIDTH data), `last` (1 bit, last granted index), `count0`/`count1`.
- Enqueue: `inN$enq__RDY = ~validN` (registered, no bypass). On `inN$enq__ENA`, capture `inN$enq$v` into slotN and set validN.
- Grant selection (combinational, from registers): only valid0 -> 0; only valid1 -> 1; both -> `~last`; neither -> no grant, `out$src` holds `last`.
- Fire: `out$enq__ENA = (valid0 | valid1) & out$enq__RDY`. `out$enq$v` = granted slot data (don't-care, but stable, when no grant).
- On fire: clear granted validN, set `last` = granted index, increment `countN` (wraps 2^COUNT_W-1 -> 0).
- A slot cannot be refilled in the cycle it is drained (RDY is registered ~valid); refill is possible the next cycle.
- ENA on a port while RDY=0 is a caller protocol violation; the block ignores it (slot content unchanged).
- Messages are never reordered within a requester; never dropped or duplicated except by reset.

## Timing
- Reset (`nRST`=0, asynchronous): valid0=valid1=0, `last`=1, counts=0. Outputs during/after reset: `in0$enq__RDY`=`in1$enq__RDY`=1, `out$enq__ENA`=0, `out$src`=1, `count0`=`count1`=0. Reset mid-operation discards held messages.
- Latency: message enqueued in cycle t is eligible at t+1; forwarded at t+1 if granted and `out$enq__RDY`=1.
- Throughput: aggregate 1 message/cycle with both requesters active; a single requester sustains 1 message per 2 cycles.
- Backpressure: `out$enq__RDY`=0 holds slots, `last`, counts unchanged; grant is re-evaluated each cycle (no locking to a pending grant).
- Fairness: with both slots continuously refilled, grants alternate 0,1,0,1…; first tie after reset goes to requester 0.
- Combinational paths: `out$enq__RDY` -> `out$enq__ENA` only; no path from any input to `inN$enq__RDY`.

## Test plan
- Reset then single message: in0 enq 0x…0001_0000_002A at t0 -> `out$enq__ENA`=1, `out$src`=0, same value at t0+1; `count0`=1 at t0+2; `in0$enq__RDY`=1 again at t0+2.
- Tie: both enqueue at t0 (A on 0, B on 1), sink ready -> A at t0+1 (src 0), B at t0+2 (src 1); counts 1/1.
- Backpressure: both slots full, `out$enq__RDY`=0 for 5 cycles -> no ENA, both RDY=0, counts static; release -> requester `~last` goes first.
- Streaming: both requesters enqueue whenever RDY for 100 cycles -> alternating src, no gaps after first message, counts differ by ≤1, order per requester preserved.
- Counter wrap: preload via 65535 forwards on port 1 -> `count1`=0xFFFF; one more -> 0x0000, `count0` unaffected.
- Async reset mid-traffic: drop `nRST` between edges with both slots full -> immediately `out$enq__ENA`=0, both RDY=1, counts 0; after release, first tie grants requester 0.
